// File: rtl/upm_thermal_chain_seq.sv
// upm_thermal_chain_seq
// Staggered per-channel power-enable sequencer for a chain of thermal CBBs,
// configured and observed through a scan TDR (capture/shift/update/sel).
// Optional build macro: UPM_THERMAL_SEQ_DEBUG_CNT_EN adds a saturating 16-bit
// go-to-done cycle counter to the TDR capture path, above the errclr field.
module upm_thermal_chain_seq #(
    parameter int unsigned NUM_CBB   = 4,
    parameter int unsigned STAGGER_W = 8,
    parameter int unsigned TIMEOUT_W = 10
) (
    input  logic               tck,
    input  logic               fdfx_powergood,
    input  logic               sel,
    input  logic               capture,
    input  logic               shift,
    input  logic               update,
    input  logic               si,
    output logic               so,
    input  logic               iso_n,
    input  logic [NUM_CBB-1:0] pwr_ack,
    output logic [NUM_CBB-1:0] pwr_en,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               power_enable_error_next
);

    localparam int unsigned IDX_W    = (NUM_CBB > 1) ? $clog2(NUM_CBB) : 1;
    localparam int unsigned CFG_W    = 2*NUM_CBB + STAGGER_W + 1;
    localparam int unsigned MASK_LSB = STAGGER_W + 1;
    localparam int unsigned CLR_LSB  = STAGGER_W + 1 + NUM_CBB;
`ifdef UPM_THERMAL_SEQ_DEBUG_CNT_EN
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned TDR_W    = CFG_W + CNT_W;
`else
    localparam int unsigned TDR_W    = CFG_W;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CBB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_WAIT_ACK,
        S_GAP,
        S_DONE
    } state_t;

    state_t               state;
    logic [TDR_W-1:0]     tdr_sr;
    logic [TDR_W-1:0]     cap_val;
    logic [NUM_CBB-1:0]   ack_meta;
    logic [NUM_CBB-1:0]   ack_sync;
    logic [NUM_CBB-1:0]   mask_q;
    logic [NUM_CBB-1:0]   err_q;
    logic [NUM_CBB-1:0]   err_clr;
    logic [STAGGER_W-1:0] stagger_q;
    logic [STAGGER_W-1:0] gap_cnt;
    logic [TIMEOUT_W-1:0] timer;
    logic [IDX_W-1:0]     idx;

    logic                 cap_fire;
    logic                 shift_fire;
    logic                 upd_fire;
    logic                 upd_go;
    logic [STAGGER_W-1:0] upd_stagger;
    logic [NUM_CBB-1:0]   upd_mask;
    logic [NUM_CBB-1:0]   upd_errclr;
    logic                 idle_like;
    logic                 seq_start;
    logic                 at_last;

`ifdef UPM_THERMAL_SEQ_DEBUG_CNT_EN
    logic [CNT_W-1:0]     dbg_cnt;
`endif

    // TDR access decode (capture > shift > update) and field extraction
    always_comb begin
        cap_fire    = sel & capture;
        shift_fire  = sel & shift & ~capture;
        upd_fire    = sel & update & ~capture & ~shift;
        upd_go      = tdr_sr[0];
        upd_stagger = tdr_sr[STAGGER_W:1];
        upd_mask    = tdr_sr[MASK_LSB +: NUM_CBB];
        upd_errclr  = tdr_sr[CLR_LSB +: NUM_CBB];
        err_clr     = upd_fire ? upd_errclr : '0;
        idle_like   = (state == S_IDLE) || (state == S_DONE);
        seq_start   = upd_fire & upd_go & iso_n & idle_like;
        at_last     = (idx == LAST_IDX);
`ifdef UPM_THERMAL_SEQ_DEBUG_CNT_EN
        cap_val     = {dbg_cnt, err_q, ack_sync, stagger_q, seq_busy};
`else
        cap_val     = {err_q, ack_sync, stagger_q, seq_busy};
`endif
    end

    assign so                      = tdr_sr[0];
    assign power_enable_error_next = |err_q;

    // Two-flop synchroniser for the asynchronous power-good acks
    always_ff @(posedge tck or negedge fdfx_powergood) begin
        if (!fdfx_powergood) begin
            ack_meta <= '0;
            ack_sync <= '0;
        end else begin
            ack_meta <= pwr_ack;
            ack_sync <= ack_meta;
        end
    end

    // TDR shift register: capture status or shift toward LSB
    always_ff @(posedge tck or negedge fdfx_powergood) begin
        if (!fdfx_powergood) begin
            tdr_sr <= '0;
        end else if (cap_fire) begin
            tdr_sr <= cap_val;
        end else if (shift_fire) begin
            tdr_sr <= {si, tdr_sr[TDR_W-1:1]};
        end
    end

    // Configuration fields latched on update
    always_ff @(posedge tck or negedge fdfx_powergood) begin
        if (!fdfx_powergood) begin
            stagger_q <= '0;
            mask_q    <= '0;
        end else if (upd_fire) begin
            stagger_q <= upd_stagger;
            mask_q    <= upd_mask;
        end
    end

    // Sequencer: staggered bring-up, ack timeout, sticky errors, isolation
    always_ff @(posedge tck or negedge fdfx_powergood) begin
        if (!fdfx_powergood) begin
            state    <= S_IDLE;
            idx      <= '0;
            timer    <= '0;
            gap_cnt  <= '0;
            pwr_en   <= '0;
            err_q    <= '0;
            seq_busy <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            // errclr applies in every state; a timeout below overrides its own bit
            err_q <= err_q & ~err_clr;
            if (!iso_n) begin
                state    <= S_IDLE;
                pwr_en   <= '0;
                seq_busy <= 1'b0;
                seq_done <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (seq_start) begin
                            state    <= S_NEXT;
                            idx      <= '0;
                            seq_busy <= 1'b1;
                            seq_done <= 1'b0;
                        end else if (upd_fire && !upd_go) begin
                            pwr_en <= pwr_en & upd_mask;
                        end
                    end
                    S_NEXT: begin
                        if (mask_q[idx]) begin
                            pwr_en[idx] <= 1'b1;
                            timer       <= '0;
                            state       <= S_WAIT_ACK;
                        end else if (at_last) begin
                            state    <= S_DONE;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (ack_sync[idx] || (timer == '1)) begin
                            if (!ack_sync[idx]) begin
                                err_q[idx]  <= 1'b1;
                                pwr_en[idx] <= 1'b0;
                            end
                            // A zero stagger bypasses GAP so the next channel follows directly
                            if (stagger_q != '0) begin
                                gap_cnt <= STAGGER_W'(1);
                                state   <= S_GAP;
                            end else if (at_last) begin
                                state    <= S_DONE;
                                seq_busy <= 1'b0;
                                seq_done <= 1'b1;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_NEXT;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt >= stagger_q) begin
                            if (at_last) begin
                                state    <= S_DONE;
                                seq_busy <= 1'b0;
                                seq_done <= 1'b1;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_NEXT;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef UPM_THERMAL_SEQ_DEBUG_CNT_EN
    // Saturating go-to-done cycle counter, held until the next go
    always_ff @(posedge tck or negedge fdfx_powergood) begin
        if (!fdfx_powergood) begin
            dbg_cnt <= '0;
        end else if (seq_start) begin
            dbg_cnt <= '0;
        end else if (seq_busy && (dbg_cnt != '1)) begin
            dbg_cnt <= dbg_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/upm_thermal_chain_seq.md
Name: upm_thermal_chain_seq

Overview:
- Parametrised power-enable sequencer for a chain of NUM_CBB thermal CBBs.
- Replaces the fixed prev/next power_enable daisy chain with a per-channel staggered bring-up, ack timeout and sticky error reporting.
- Configured and observed through a TDR on the standard shift/capture/update/sel scan interface.
- Sits between the UPM scan fabric and the thermal CBB power switches.

Parameters:
- NUM_CBB, 4, number of thermal CBB channels (1..16).
- STAGGER_W, 8, width of the inter-channel gap field, in tck cycles.
- TIMEOUT_W, 10, width of the ack timeout counter; timeout = 2^TIMEOUT_W-1 cycles.

Ports:
- tck  input  1  clock; all logic on rising edge.
- fdfx_powergood  input  1  asynchronous active-low reset.
- sel  input  1  TDR select; shift/capture/update ignored when 0.
- capture  input  1  load status into the TDR shift register.
- shift  input  1  shift TDR one bit toward LSB; si enters MSB.
- update  input  1  transfer shift register to the config fields.
- si  input  1  scan in.
- so  output  1  scan out = shift register bit 0, a flop output.
- iso_n  input  1  active-low isolation; forces power-down.
- pwr_ack  input  NUM_CBB  per-channel power-good, asynchronous.
- pwr_en  output  NUM_CBB  per-channel power enable.
- seq_busy  output  1  sequence in progress.
- seq_done  output  1  last sequence completed; cleared by the next go.
- power_enable_error_next  output  1  OR of the error vector.

Behaviour:
- Reset: all flops 0; pwr_en=0, so=0, seq_busy=0, seq_done=0, power_enable_error_next=0; FSM=IDLE.
- TDR width TDR_W = 2*NUM_CBB+STAGGER_W+1.
  - Fields, LSB first: go[0], stagger[STAGGER_W:1], mask[NUM_CBB fields], errclr[top NUM_CBB].
  - Priority when sel=1: capture > shift > update.
- Capture loads: busy into go, current stagger, 2-flop-synced ack vector into mask, error vector into errclr.
- Update:
  - Latches stagger and mask.
  - errclr is write-1-to-clear on the error vector, effective next cycle.
  - go=1 in IDLE or DONE starts a sequence; go=1 while busy is ignored.
  - go=0 in IDLE or DONE applies pwr_en &= mask on the next cycle (selective power-down).
- pwr_ack passes through a 2-flop synchroniser before any use.
- FSM states: IDLE, NEXT, WAIT_ACK, GAP, DONE.
  - IDLE -go-> NEXT, idx=0, seq_done=0, seq_busy=1.
  - NEXT: if mask[idx]=0, advance idx (1 cycle per skipped channel). Otherwise set pwr_en[idx]=1, clear the timer, go to WAIT_ACK. pwr_en[0] is therefore high 2 cycles after the update cycle.
  - WAIT_ACK: on synced ack[idx], go to GAP. If the timer reaches 2^TIMEOUT_W-1 without ack: err[idx]=1, pwr_en[idx]=0, go to GAP. Ack and timeout in the same cycle: ack wins, no error.
  - GAP: count stagger cycles (stagger=0 gives 0 extra cycles). At the end, if idx=NUM_CBB-1 go to DONE, else idx+1 and NEXT.
  - DONE: seq_busy=0, seq_done=1; pwr_en is held; go restarts from NEXT.
- pwr_en bits are sticky. A bit clears only on timeout, iso_n=0, masked power-down, or reset.
- iso_n=0 (sampled synchronously): pwr_en=0, FSM=IDLE, busy=0, done=0. The error vector and config are preserved. TDR access still works.
- Reset mid-sequence: immediate return to the reset state; no partial-state retention.
- A channel that has already acked and later drops ack is not re-checked. Errors come only from timeouts.
- NUM_CBB=1: idx logic degenerates; behaviour is identical for the single channel.

Optional Feature:
- Macro: UPM_THERMAL_SEQ_DEBUG_CNT_EN.
- When defined:
  - TDR_W grows by 16; the extra field sits above errclr.
  - Capture loads a 16-bit cycle count from the go that started the last sequence to DONE. The count saturates at 0xFFFF and is held until the next go.
  - Update ignores these bits.
- When undefined: no counter, TDR_W = 2*NUM_CBB+STAGGER_W+1, and so timing is unchanged.

Test Plan:
- Reset: assert fdfx_powergood=0 mid-shift -> so=0, pwr_en=4'b0000, busy=0, done=0, error=0 immediately.
- Full sequence: NUM_CBB=4, stagger=3, mask=4'b1111, go=1; acks return 5 cycles after each pwr_en -> pwr_en fills 0001, 0011, 0111, 1111. Each channel enable is exactly 3 GAP cycles after the synced ack of the previous one. Then done=1, busy=0.
- Mask skip: mask=4'b1010 -> only pwr_en[1] and pwr_en[3] rise; 1 cycle spent per skipped channel; done=1.
- Timeout: hold pwr_ack[2]=0 -> after 1023 WAIT_ACK cycles, pwr_en[2]=0 and power_enable_error_next=1. Capture shows errclr field 4'b0100. Update with errclr=4'b0100 -> error=0 next cycle.
- Ack/timeout race: synced ack[0] arrives on timer=1023 -> no error, and the sequence proceeds.
- Isolation and busy-go: iso_n=0 during WAIT_ACK on ch1 -> pwr_en=0, IDLE. Separately, a go during a busy sequence is ignored: the idx trace is unchanged.
